// File: rtl/countdown_pkg.sv
// Shared types and constants for the N-digit BCD countdown timer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package countdown_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Active-high seven-segment patterns for 0..9, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_PATTERN [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-BCD digits saturate to 9 so the count can never hold an undecodable value
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/countdown_timer_n_if.sv
// Control/display bundle between button logic, the timer, and the display/buzzer pins.
// Latency: none (wiring only).
// Backpressure: none; controls are single-cycle pulses, outputs are levels.
//   master: drives start/pause/load/load_value, observes seg/beep/done/running
//   slave : the timer itself
interface countdown_timer_n_if #(
    parameter int DIGITS = 2
);
    logic                  start;
    logic                  pause;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [7*DIGITS-1:0]   seg;
    logic                  beep;
    logic                  done;
    logic                  running;

    modport master (
        output start, pause, load, load_value,
        input  seg, beep, done, running
    );

    modport slave (
        input  start, pause, load, load_value,
        output seg, beep, done, running
    );
endinterface

// File: rtl/countdown_timer_n_bcd_to_seg.sv
// One-digit BCD to seven-segment decoder, optional output inversion for common-anode parts.
// Latency: combinational.
// Backpressure: none.
//   i_bcd : 4-bit BCD digit
//   o_seg : {g,f,e,d,c,b,a}, blank for codes above 9
module bcd_to_seg
    import countdown_pkg::*;
#(
    parameter bit ACT_LOW = 1'b1
) (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    logic [6:0] w_pat;

    always_comb begin
        w_pat = SEG_BLANK;
        if (i_bcd <= 4'd9) begin
            w_pat = SEG_PATTERN[i_bcd];
        end
    end

    assign o_seg = ACT_LOW ? ~w_pat : w_pat;

endmodule

// File: rtl/countdown_timer_n.sv
// N-digit BCD countdown timer: prescaled tick, run-time load, start/pause/restart, sticky done, bounded beep.
// Latency: count/state/running/done/beep registered; seg is a combinational decode of the count register.
// Backpressure: none; start/pause/load are sampled every cycle with priority load > pause > start.
//   i_clock, i_reset : clock and synchronous active-high reset
//   io_bus           : start/pause/load/load_value in, seg/beep/done/running out
module countdown_timer_n
    import countdown_pkg::*;
#(
    parameter int                  DIGITS      = 2,
    parameter int                  TICK_DIV    = 50,
    parameter logic [4*DIGITS-1:0] START_VALUE = 'h10,
    parameter int                  BEEP_CYCLES = 10,
    parameter bit                  SEG_ACT_LOW = 1'b1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    countdown_timer_n_if.slave   io_bus
);

    // A one-clock tick still needs a 1-bit prescaler that simply stays at its last value
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

    state_t              r_state;
    logic [4*DIGITS-1:0] r_count;
    logic [4*DIGITS-1:0] r_preset;
    logic [PW-1:0]       r_pre;
    logic [BW-1:0]       r_beep_cnt;
    logic                r_beep;
    logic                r_done;
    logic                r_running;

    logic [4*DIGITS-1:0] w_load_clamped;
    logic [4*DIGITS-1:0] w_count_dec;
    logic                w_borrow;
    logic                w_count_zero;
    logic                w_dec_zero;
    logic                w_preset_zero;
    logic [7*DIGITS-1:0] w_seg;

    always_comb begin
        w_load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_load_clamped[4*i +: 4] = clamp_digit(io_bus.load_value[4*i +: 4]);
        end
    end

    // BCD decrement: borrow ripples upward from the least significant digit
    always_comb begin
        w_borrow    = 1'b1;
        w_count_dec = r_count;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_count_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_borrow              = 1'b0;
                end
            end
        end
    end

    assign w_count_zero  = (r_count == '0);
    assign w_dec_zero    = (w_count_dec == '0);
    assign w_preset_zero = (r_preset == '0);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_count    <= START_VALUE;
            r_preset   <= START_VALUE;
            r_pre      <= '0;
            r_beep_cnt <= '0;
            r_beep     <= 1'b0;
            r_done     <= 1'b0;
            r_running  <= 1'b0;
        end else if (io_bus.load) begin
            r_state    <= IDLE;
            r_count    <= w_load_clamped;
            r_preset   <= w_load_clamped;
            r_pre      <= '0;
            r_beep_cnt <= '0;
            r_beep     <= 1'b0;
            r_done     <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.start) begin
                        r_pre <= '0;
                        if (w_count_zero) begin
                            r_state    <= EXPIRED;
                            r_done     <= 1'b1;
                            r_beep     <= 1'b1;
                            r_beep_cnt <= BEEP_LAST;
                        end else begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (io_bus.pause) begin
                        r_state   <= PAUSED;
                        r_running <= 1'b0;
                    end else if (r_pre == PRE_LAST) begin
                        r_pre <= '0;
                        // Zero guard keeps the count from wrapping even if RUN is entered at 0
                        if (!w_count_zero) begin
                            r_count <= w_count_dec;
                            if (w_dec_zero) begin
                                r_state    <= EXPIRED;
                                r_running  <= 1'b0;
                                r_done     <= 1'b1;
                                r_beep     <= 1'b1;
                                r_beep_cnt <= BEEP_LAST;
                            end
                        end
                    end else begin
                        r_pre <= r_pre + PW'(1);
                    end
                end

                PAUSED: begin
                    if (io_bus.start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end

                EXPIRED: begin
                    if (io_bus.start) begin
                        r_count <= r_preset;
                        r_pre   <= '0;
                        // A zero preset would leave RUN stuck at 0, so restart straight into a fresh expiry
                        if (w_preset_zero) begin
                            r_done     <= 1'b1;
                            r_beep     <= 1'b1;
                            r_beep_cnt <= BEEP_LAST;
                        end else begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                            r_done    <= 1'b0;
                            r_beep    <= 1'b0;
                        end
                    end else if (r_beep) begin
                        // beep_cnt holds the remaining high cycles after the current one
                        if (r_beep_cnt == '0) begin
                            r_beep <= 1'b0;
                        end else begin
                            r_beep_cnt <= r_beep_cnt - BW'(1);
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_to_seg #(
            .ACT_LOW (SEG_ACT_LOW)
        ) u_bcd_to_seg (
            .i_bcd (r_count[4*g +: 4]),
            .o_seg (w_seg[7*g +: 7])
        );
    end

    assign io_bus.seg     = w_seg;
    assign io_bus.beep    = r_beep;
    assign io_bus.done    = r_done;
    assign io_bus.running = r_running;

endmodule
